// File: rtl/controller_mc_g7.sv
// Multicycle RV32I control unit: Moore main FSM, ALU decoder and illegal-instruction detection
// for the group-7 shared datapath (single memory port, IR/OldPC, A/B/ALUOut registers).
module controller_mc_g7 #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] ALUControl,
    output logic       illegal_instr
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    typedef enum logic [1:0] { ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT } aluop_t;

    state_t r_state, w_next;
    aluop_t w_alu_op;
    logic   w_pc_update, w_branch, w_illegal, r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == S_DECODE) && w_illegal;
        end
    end

    // R-type only accepts funct7b5=1 for sub; srai/sra are unsupported.
    always_comb begin
        w_illegal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE: w_illegal = (funct3 != 3'b010);
            OP_RTYPE: begin
                case (funct3)
                    3'b000:                 w_illegal = 1'b0;
                    3'b101, 3'b110, 3'b111: w_illegal = funct7b5;
                    default:                w_illegal = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                case (funct3)
                    3'b000, 3'b110, 3'b111: w_illegal = 1'b0;
                    3'b101:                 w_illegal = funct7b5;
                    default:                w_illegal = 1'b1;
                endcase
            end
            OP_BEQ:  w_illegal = (funct3 != 3'b000);
            OP_JAL:  w_illegal = 1'b0;
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_alu_op    = ALUOP_ADD;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (r_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (w_illegal) begin
                    w_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_RTYPE:          w_next = S_EXECR;
                        OP_ITYPE:          w_next = S_EXECI;
                        OP_BEQ:            w_next = S_BEQ;
                        OP_JAL:            w_next = S_JAL;
                        default:           w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    assign PCWrite       = w_pc_update | (w_branch & zero);
    assign illegal_instr = r_illegal;

    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        case (w_alu_op)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    3'b101:  ALUControl = ALU_SRL;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: tb/tb_controller_mc_g7.sv
// Self-checking bench for controller_mc_g7: directed vector table, reset/trap sequences,
// and random instruction streams checked against an instruction-level reference model.
module tb_controller_mc_g7;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd5;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic       f7 = 1'b0, zero = 1'b0;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
    logic       PCWrite_t, AdrSrc_t, MemWrite_t, IRWrite_t, RegWrite_t, illegal_t;
    logic [1:0] ResultSrc_t, ALUSrcA_t, ALUSrcB_t, ImmSrc_t;
    logic [3:0] ALUControl_t;

    controller_mc_g7 #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(rst0), .op(op), .funct3(f3), .funct7b5(f7), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal_instr(illegal)
    );

    controller_mc_g7 #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(rst1), .op(op), .funct3(f3), .funct7b5(f7), .zero(zero),
        .PCWrite(PCWrite_t), .AdrSrc(AdrSrc_t), .MemWrite(MemWrite_t), .IRWrite(IRWrite_t),
        .ResultSrc(ResultSrc_t), .ALUSrcA(ALUSrcA_t), .ALUSrcB(ALUSrcB_t), .ImmSrc(ImmSrc_t),
        .RegWrite(RegWrite_t), .ALUControl(ALUControl_t), .illegal_instr(illegal_t)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef enum { ST_F, ST_D, ST_MA, ST_MR, ST_MWB, ST_MW, ST_ER, ST_EI, ST_WB, ST_BQ, ST_J } step_t;
    typedef step_t seq_t[$];

    function automatic bit is_legal(input logic [6:0] o, input logic [2:0] fn3, input logic b5);
        case (o)
            7'h03, 7'h23: return fn3 == 3'd2;
            7'h33: return (fn3 == 3'd0) || (!b5 && (fn3 == 3'd5 || fn3 == 3'd6 || fn3 == 3'd7));
            7'h13: return (fn3 == 3'd0 || fn3 == 3'd6 || fn3 == 3'd7) || (fn3 == 3'd5 && !b5);
            7'h63: return fn3 == 3'd0;
            7'h6f: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int funct_alu(input logic [6:0] o, input logic [2:0] fn3, input logic b5);
        case (fn3)
            3'd0: return (o == 7'h33 && b5) ? int'(ALU_SUB) : int'(ALU_ADD);
            3'd7: return int'(ALU_AND);
            3'd6: return int'(ALU_OR);
            3'd5: return int'(ALU_SRL);
            default: return int'(ALU_ADD);
        endcase
    endfunction

    function automatic int imm_of(input logic [6:0] o);
        if (o == 7'h23) return 1;
        if (o == 7'h63) return 2;
        if (o == 7'h6f) return 3;
        return 0;
    endfunction

    // Instruction-level model: the cycle-by-cycle phases an instruction goes through.
    function automatic seq_t build(input logic [6:0] o, input logic [2:0] fn3, input logic b5);
        seq_t s;
        s = '{ST_F, ST_D};
        if (!is_legal(o, fn3, b5)) return s;
        case (o)
            7'h03: begin s.push_back(ST_MA); s.push_back(ST_MR); s.push_back(ST_MWB); end
            7'h23: begin s.push_back(ST_MA); s.push_back(ST_MW); end
            7'h33: begin s.push_back(ST_ER); s.push_back(ST_WB); end
            7'h13: begin s.push_back(ST_EI); s.push_back(ST_WB); end
            7'h63: s.push_back(ST_BQ);
            default: begin s.push_back(ST_J); s.push_back(ST_WB); end
        endcase
        return s;
    endfunction

    task automatic check_step(input step_t st, input bit exp_ill);
        int e_pcw = 0, e_mw = 0, e_irw = 0, e_rw = 0;
        int e_adr = -1, e_res = -1, e_a = -1, e_b = -1, e_alu = -1;
        string n = st.name();
        case (st)
            ST_F:   begin e_pcw = 1; e_irw = 1; e_adr = 0; e_a = 0; e_b = 2; e_alu = int'(ALU_ADD); e_res = 2; end
            ST_D:   begin e_a = 1; e_b = 1; e_alu = int'(ALU_ADD); end
            ST_MA:  begin e_a = 2; e_b = 1; e_alu = int'(ALU_ADD); end
            ST_MR:  begin e_adr = 1; e_res = 0; end
            ST_MWB: begin e_res = 1; e_rw = 1; end
            ST_MW:  begin e_adr = 1; e_res = 0; e_mw = 1; end
            ST_ER:  begin e_a = 2; e_b = 0; e_alu = funct_alu(op, f3, f7); end
            ST_EI:  begin e_a = 2; e_b = 1; e_alu = funct_alu(op, f3, f7); end
            ST_WB:  begin e_res = 0; e_rw = 1; end
            ST_BQ:  begin e_a = 2; e_b = 0; e_alu = int'(ALU_SUB); e_res = 0; e_pcw = int'(zero); end
            default: begin e_a = 1; e_b = 2; e_alu = int'(ALU_ADD); e_res = 0; e_pcw = 1; end
        endcase
        chk({"PCWrite@", n}, 32'(PCWrite), e_pcw);
        chk({"MemWrite@", n}, 32'(MemWrite), e_mw);
        chk({"IRWrite@", n}, 32'(IRWrite), e_irw);
        chk({"RegWrite@", n}, 32'(RegWrite), e_rw);
        chk({"illegal@", n}, 32'(illegal), 32'(exp_ill));
        chk({"ImmSrc@", n}, 32'(ImmSrc), imm_of(op));
        if (e_adr >= 0) chk({"AdrSrc@", n}, 32'(AdrSrc), e_adr);
        if (e_res >= 0) chk({"ResultSrc@", n}, 32'(ResultSrc), e_res);
        if (e_a >= 0)   chk({"ALUSrcA@", n}, 32'(ALUSrcA), e_a);
        if (e_b >= 0)   chk({"ALUSrcB@", n}, 32'(ALUSrcB), e_b);
        if (e_alu >= 0) chk({"ALUControl@", n}, 32'(ALUControl), e_alu);
    endtask

    // Leaves dut0 in FETCH at posedge+1 with reset released.
    task automatic do_reset();
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         lat;
        logic [3:0] alu3;
        logic       pcw3;
        logic       ill;
    } vec_t;

    vec_t tab[$];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        seq_t s;
        int   n;
        bit   prev_ill, any_wr;
        int   pick;
        logic [6:0] ops [6];
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h6f;

        //            op     f3    f7  z  lat alu@3   pcw ill
        tab.push_back('{7'h03, 3'd2, 0, 0, 5, ALU_ADD, 0, 0});
        tab.push_back('{7'h23, 3'd2, 0, 0, 4, ALU_ADD, 0, 0});
        tab.push_back('{7'h33, 3'd0, 1, 0, 4, ALU_SUB, 0, 0});
        tab.push_back('{7'h33, 3'd0, 0, 0, 4, ALU_ADD, 0, 0});
        tab.push_back('{7'h13, 3'd0, 1, 0, 4, ALU_ADD, 0, 0});
        tab.push_back('{7'h33, 3'd5, 0, 0, 4, ALU_SRL, 0, 0});
        tab.push_back('{7'h33, 3'd6, 0, 0, 4, ALU_OR,  0, 0});
        tab.push_back('{7'h13, 3'd7, 1, 1, 4, ALU_AND, 0, 0});
        tab.push_back('{7'h63, 3'd0, 0, 1, 3, ALU_SUB, 1, 0});
        tab.push_back('{7'h63, 3'd0, 0, 0, 3, ALU_SUB, 0, 0});
        tab.push_back('{7'h6f, 3'd3, 1, 0, 4, ALU_ADD, 1, 0});
        tab.push_back('{7'h00, 3'd0, 0, 0, 2, ALU_ADD, 1, 1});
        tab.push_back('{7'h33, 3'd5, 1, 0, 2, ALU_ADD, 1, 1});
        tab.push_back('{7'h03, 3'd0, 0, 0, 2, ALU_ADD, 1, 1});
        tab.push_back('{7'h33, 3'd1, 0, 0, 2, ALU_ADD, 1, 1});
        tab.push_back('{7'h63, 3'd1, 0, 1, 2, ALU_ADD, 1, 1});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset IRWrite", 32'(IRWrite), 1);
        chk("reset PCWrite", 32'(PCWrite), 1);
        chk("reset illegal", 32'(illegal), 0);
        chk("reset MemWrite", 32'(MemWrite), 0);
        chk("reset RegWrite", 32'(RegWrite), 0);

        // Directed vector table
        foreach (tab[i]) begin
            do_reset();
            op = tab[i].op; f3 = tab[i].f3; f7 = tab[i].f7; zero = tab[i].zero;
            n = 0;
            any_wr = 1'b0;
            do begin
                #1;
                any_wr |= RegWrite | MemWrite;
                if (n == 2) begin
                    chk($sformatf("vec%0d ALUControl@3", i), 32'(ALUControl), 32'(tab[i].alu3));
                    chk($sformatf("vec%0d PCWrite@3", i), 32'(PCWrite), 32'(tab[i].pcw3));
                    chk($sformatf("vec%0d illegal@3", i), 32'(illegal), 32'(tab[i].ill));
                end
                @(posedge clk); #1;
                n++;
            end while (IRWrite !== 1'b1 && n < 12);
            chk($sformatf("vec%0d latency", i), n, tab[i].lat);
            if (tab[i].ill) chk($sformatf("vec%0d no write", i), 32'(any_wr), 0);
        end

        // Reset asserted mid-MEMREAD takes effect without a clock edge
        do_reset();
        op = 7'h03; f3 = 3'd2; f7 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("memread AdrSrc", 32'(AdrSrc), 1);
        rst0 = 1'b1;
        #1;
        chk("async rst IRWrite", 32'(IRWrite), 1);
        chk("async rst PCWrite", 32'(PCWrite), 1);
        chk("async rst AdrSrc", 32'(AdrSrc), 0);
        chk("async rst illegal", 32'(illegal), 0);
        rst0 = 1'b0;
        @(posedge clk); #1;
        chk("post rst ALUSrcA", 32'(ALUSrcA), 1);
        chk("post rst IRWrite", 32'(IRWrite), 0);

        // Reset clears an in-flight illegal pulse asynchronously
        do_reset();
        op = 7'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pulse before rst", 32'(illegal), 1);
        rst0 = 1'b1;
        #1;
        chk("pulse cleared by rst", 32'(illegal), 0);
        @(posedge clk); #1;
        rst0 = 1'b0;

        // Random instruction stream against the model
        prev_ill = 1'b0;
        repeat (300) begin
            pick = $urandom_range(0, 7);
            op = (pick < 6) ? ops[pick] : 7'($urandom);
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            if ((op == 7'h03 || op == 7'h23) && $urandom_range(0, 3) != 0) f3 = 3'd2;
            if (op == 7'h63 && $urandom_range(0, 3) != 0) f3 = 3'd0;
            s = build(op, f3, f7);
            foreach (s[k]) begin
                zero = 1'($urandom);
                #1;
                check_step(s[k], (k == 0) && prev_ill);
                @(posedge clk); #1;
            end
            prev_ill = !is_legal(op, f3, f7);
        end

        // Trap variant: park in TRAP until reset
        rst0 = 1'b1;
        op = 7'h00; f3 = 3'd0; f7 = 1'b0; zero = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("trap FETCH IRWrite", 32'(IRWrite_t), 1);
        @(posedge clk); #1;
        chk("trap DECODE ALUSrcA", 32'(ALUSrcA_t), 1);
        chk("trap DECODE illegal", 32'(illegal_t), 0);
        @(posedge clk); #1;
        chk("trap pulse", 32'(illegal_t), 1);
        op = 7'h03; f3 = 3'd2;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("trap%0d enables", c),
                32'({PCWrite_t, MemWrite_t, IRWrite_t, RegWrite_t}), 0);
            @(posedge clk); #1;
            chk($sformatf("trap%0d illegal", c), 32'(illegal_t), 0);
        end
        rst1 = 1'b1;
        #1;
        chk("trap rst IRWrite", 32'(IRWrite_t), 1);
        chk("trap rst PCWrite", 32'(PCWrite_t), 1);
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(posedge clk); #1;
        chk("trap exit DECODE", 32'(ALUSrcA_t), 1);
        chk("trap exit IRWrite", 32'(IRWrite_t), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
